game_state_controller: RTL and testbench
========================================

Name: game_state_controller

Overview:
Game-flow and player-statistics stage that sits upstream of the ball/paddle playfield and scoreboard renderer. It consumes brick-hit and ball-lost event pulses from the playfield, and a start button. It produces the BCD score digits and lives count for the scoreboard, plus freeze, serve and brick-wall-reload controls for the playfield. All logic is synchronous to the pixel clock; time-outs are counted in frames.

Parameters:
START_LIVES, 3, lives loaded at game start (1..9)
BRICKS_TOTAL, 128, bricks per wall (16x8)
SERVE_FRAMES, 60, frames the ball is held before serve
LOST_FRAMES, 90, pause frames after a lost ball
CLEAR_FRAMES, 120, pause frames after a wall is cleared
OVER_FRAMES, 180, frames GAME_OVER is shown before returning to IDLE

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
frame_start  in  1  one-clk pulse per frame (vsync rising edge, already synchronised)
brick_hit  in  1  one-clk pulse per brick destroyed
ball_lost  in  1  one-clk pulse when the ball passes the paddle row
start_btn  in  1  level, already synchronised
score0  out  4  BCD ones digit
score1  out  4  BCD tens digit
lives  out  4  lives remaining, binary 0..9
state  out  3  current FSM state code
ball_freeze  out  1  1 = playfield must hold the ball still
ball_serve  out  1  one-clk pulse: reposition and launch the ball
clear_bricks  out  1  one-clk pulse: playfield reloads the full brick array
game_over  out  1  1 while in OVER

Behaviour:
- Reset values:
  - state=IDLE, score=00, lives=0, bricks_left=BRICKS_TOTAL, frame timer=0.
  - ball_freeze=1; ball_serve, clear_bricks, game_over all 0.
- States: IDLE=0, SERVE=1, PLAY=2, LOST=3, CLEAR=4, OVER=5; codes 6-7 unreachable and recover to IDLE.
- Frame timer: 8-bit; zeroed on every state entry; increments on each frame_start.
- IDLE (ball_freeze=1): start_btn=1 -> SERVE. On that same clk edge:
  - score=00, lives=START_LIVES, bricks_left=BRICKS_TOTAL;
  - clear_bricks pulses 1 the following cycle.
- SERVE (ball_freeze=1): when the timer reaches SERVE_FRAMES, ball_serve pulses for exactly one clk and the next state is PLAY.
- PLAY (ball_freeze=0):
  - brick_hit: score+1 in BCD (ones 9 -> 0 with tens carry); saturates at 99, no wrap. bricks_left decrements.
  - If bricks_left was 1 at the hit -> CLEAR.
  - ball_lost: lives decrements. If lives was 1 -> OVER (lives=0); otherwise -> LOST.
  - Simultaneous brick_hit and ball_lost: the hit is scored first. If that hit empties the wall -> CLEAR and the loss is ignored (lives unchanged).
- LOST (ball_freeze=1): timer == LOST_FRAMES -> SERVE.
- CLEAR (ball_freeze=1): timer == CLEAR_FRAMES -> SERVE. On exit: clear_bricks pulses one clk, bricks_left reloads, score is retained.
- OVER (ball_freeze=1, game_over=1): score and lives are held for display.
  - timer == OVER_FRAMES -> IDLE.
  - start_btn while the timer is below 30 is ignored (debounce). At 30 or above it starts a new game exactly as from IDLE.
- Ignored events:
  - brick_hit and ball_lost outside PLAY have no effect.
  - start_btn outside IDLE/OVER is ignored.
- Pulse rules:
  - All outputs are registered; event-to-output latency is 1 clk.
  - ball_serve and clear_bricks never assert in the same cycle.
- Reset asserted mid-game returns all outputs to their reset values immediately (asynchronous).

Optional Feature:
EXTRA_LIFE_EN
- Defined: a brick_hit that moves the score from 49 to 50, or from 98 or 99 into the saturated 99, grants +1 life (saturating at 9). The 99 award is granted once per game. The grant is applied in the same cycle as the score update. If ball_lost coincides with the grant, the net lives change is 0 and the FSM goes to LOST.
- Undefined: lives change only at game start and on ball_lost.

Decomposition:
- Package game_pkg holds:
  - state encoding constants;
  - default values for BRICKS_TOTAL and START_LIVES;
  - the BCD digit width (4) and max lives (9).
- One sub-module, bcd2_sat_counter: two-digit BCD counter with synchronous clear and increment enable, saturating at 99, exposing the current value.

Test Plan:
- Reset, then start_btn=1 for 1 clk -> IDLE->SERVE; clear_bricks one pulse; lives=3, score=00; after 60 frame_start pulses, ball_serve one pulse and state=PLAY.
- In PLAY, 15 brick_hit pulses -> score1=1, score0=5; 100 further hits -> score holds at 99.
- In PLAY with lives=3, ball_lost -> lives=2, LOST; after 90 frames -> SERVE; then with lives=1, ball_lost -> OVER, game_over=1, lives=0; after 180 frames -> IDLE.
- bricks_left=1 with brick_hit and ball_lost on the same clk -> CLEAR, lives unchanged; after 120 frames, one clear_bricks pulse and bricks_left=128.
- brick_hit in SERVE/LOST, and start_btn in PLAY -> no change to score, lives or state; reset pulsed in PLAY -> all outputs at reset values on the next sample.
- With EXTRA_LIFE_EN: score 49, lives 2, brick_hit -> score 50, lives 3. Without the macro -> lives stays 2.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding, widths and defaults for the game-flow controller.
package game_pkg;

  localparam int unsigned STATE_W              = 3;
  localparam int unsigned BCD_W                = 4;
  localparam int unsigned LIVES_W              = 4;
  localparam int unsigned TIMER_W              = 8;
  localparam int unsigned MAX_LIVES            = 9;
  localparam int unsigned START_LIVES_DEF      = 3;
  localparam int unsigned BRICKS_TOTAL_DEF     = 128;
  localparam int unsigned OVER_DEBOUNCE_FRAMES = 30;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  // Add one life, holding at the display maximum.
  function automatic logic [LIVES_W-1:0] lives_inc_sat(input logic [LIVES_W-1:0] l);
    return (l >= LIVES_W'(MAX_LIVES)) ? LIVES_W'(MAX_LIVES) : l + LIVES_W'(1);
  endfunction

endpackage

// File: rtl/bcd2_sat_counter.sv
// Two-digit BCD up-counter with synchronous clear; holds at 99 instead of wrapping.
module bcd2_sat_counter
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens
);

  logic [BCD_W-1:0] ones_d, ones_q;
  logic [BCD_W-1:0] tens_d, tens_q;
  logic             at_max_c;

  assign at_max_c = (ones_q == BCD_W'(9)) && (tens_q == BCD_W'(9));

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc && !at_max_c) begin
      if (ones_q == BCD_W'(9)) begin
        ones_d = '0;
        tens_d = tens_q + BCD_W'(1);
      end else begin
        ones_d = ones_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/game_state_controller.sv
// Game flow, score and lives for the brick-breaker playfield.
// Optional EXTRA_LIFE_EN: bonus lives at score 50 and once on reaching 99.
module game_state_controller
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES  = START_LIVES_DEF,
  parameter int unsigned BRICKS_TOTAL = BRICKS_TOTAL_DEF,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned LOST_FRAMES  = 90,
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               brick_hit,
  input  logic               ball_lost,
  input  logic               start_btn,
  output logic [BCD_W-1:0]   score0,
  output logic [BCD_W-1:0]   score1,
  output logic [LIVES_W-1:0] lives,
  output logic [STATE_W-1:0] state,
  output logic               ball_freeze,
  output logic               ball_serve,
  output logic               clear_bricks,
  output logic               game_over
);

  localparam int unsigned BRICK_W = $clog2(BRICKS_TOTAL + 1);

  state_e               state_d, state_q;
  logic [TIMER_W-1:0]   timer_d, timer_q;
  logic [LIVES_W-1:0]   lives_d, lives_q;
  logic [BRICK_W-1:0]   bricks_d, bricks_q;
  logic                 award99_d, award99_q;
  logic                 ball_serve_d, ball_serve_q;
  logic                 clear_bricks_d, clear_bricks_q;
  logic                 ball_freeze_d, ball_freeze_q;
  logic                 game_over_d, game_over_q;

  logic                 new_game_c;
  logic                 grant_c;
  logic                 wall_done_c;
  logic                 score_inc_c;
  logic [BCD_W-1:0]     ones, tens;
  logic [2*BCD_W-1:0]   score_bcd;

  assign score_bcd = {tens, ones};

  bcd2_sat_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game_c),
    .inc   (score_inc_c),
    .ones  (ones),
    .tens  (tens)
  );

  // Next-state, statistics and output pulse logic.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    bricks_d       = bricks_q;
    award99_d      = award99_q;
    ball_serve_d   = 1'b0;
    clear_bricks_d = 1'b0;
    new_game_c     = 1'b0;
    grant_c        = 1'b0;
    score_inc_c    = 1'b0;
    wall_done_c    = brick_hit && (bricks_q == BRICK_W'(1));

    case (state_q)
      ST_IDLE: begin
        new_game_c = start_btn;
      end
      ST_SERVE: begin
        if (timer_q == TIMER_W'(SERVE_FRAMES)) begin
          state_d      = ST_PLAY;
          ball_serve_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (brick_hit) begin
          score_inc_c = 1'b1;
          bricks_d    = bricks_q - BRICK_W'(1);
`ifdef EXTRA_LIFE_EN
          if (score_bcd == 8'h49) grant_c = 1'b1;
          if (((score_bcd == 8'h98) || (score_bcd == 8'h99)) && !award99_q) begin
            grant_c   = 1'b1;
            award99_d = 1'b1;
          end
`endif
        end
        // A hit that empties the wall wins over a simultaneous loss.
        if (wall_done_c) begin
          state_d = ST_CLEAR;
          lives_d = grant_c ? lives_inc_sat(lives_q) : lives_q;
        end else if (ball_lost) begin
          if (grant_c) begin
            state_d = ST_LOST;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_LOST;
          end
        end else if (grant_c) begin
          lives_d = lives_inc_sat(lives_q);
        end
      end
      ST_LOST: begin
        if (timer_q == TIMER_W'(LOST_FRAMES)) state_d = ST_SERVE;
      end
      ST_CLEAR: begin
        if (timer_q == TIMER_W'(CLEAR_FRAMES)) begin
          state_d        = ST_SERVE;
          clear_bricks_d = 1'b1;
          bricks_d       = BRICK_W'(BRICKS_TOTAL);
        end
      end
      ST_OVER: begin
        if (start_btn && (timer_q >= TIMER_W'(OVER_DEBOUNCE_FRAMES))) begin
          new_game_c = 1'b1;
        end else if (timer_q == TIMER_W'(OVER_FRAMES)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (new_game_c) begin
      state_d        = ST_SERVE;
      lives_d        = LIVES_W'(START_LIVES);
      bricks_d       = BRICK_W'(BRICKS_TOTAL);
      award99_d      = 1'b0;
      clear_bricks_d = 1'b1;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (frame_start) begin
      timer_d = timer_q + TIMER_W'(1);
    end else begin
      timer_d = timer_q;
    end

    ball_freeze_d = (state_d != ST_PLAY);
    game_over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      lives_q        <= '0;
      bricks_q       <= BRICK_W'(BRICKS_TOTAL);
      award99_q      <= 1'b0;
      ball_serve_q   <= 1'b0;
      clear_bricks_q <= 1'b0;
      ball_freeze_q  <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lives_q        <= lives_d;
      bricks_q       <= bricks_d;
      award99_q      <= award99_d;
      ball_serve_q   <= ball_serve_d;
      clear_bricks_q <= clear_bricks_d;
      ball_freeze_q  <= ball_freeze_d;
      game_over_q    <= game_over_d;
    end
  end

  assign score0       = ones;
  assign score1       = tens;
  assign lives        = lives_q;
  assign state        = state_q;
  assign ball_freeze  = ball_freeze_q;
  assign ball_serve   = ball_serve_q;
  assign clear_bricks = clear_bricks_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: a rule-level model predicts every
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_game_state_controller;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_LOST = 3, S_CLEAR = 4, S_OVER = 5;
  localparam int N_LIVES = 3, N_BRICKS = 128;
  localparam int F_SERVE = 60, F_LOST = 90, F_CLEAR = 120, F_OVER = 180;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0, brick_hit = 1'b0, ball_lost = 1'b0, start_btn = 1'b0;
  logic [3:0] score0, score1, lives;
  logic [2:0] state;
  logic       ball_freeze, ball_serve, clear_bricks, game_over;

  game_state_controller dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .brick_hit    (brick_hit),
    .ball_lost    (ball_lost),
    .start_btn    (start_btn),
    .score0       (score0),
    .score1       (score1),
    .lives        (lives),
    .state        (state),
    .ball_freeze  (ball_freeze),
    .ball_serve   (ball_serve),
    .clear_bricks (clear_bricks),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] lv;
    logic [2:0] st;
    logic       frz;
    logic       srv;
    logic       clr;
    logic       ovr;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_got, mon_exp;
  int   tests = 0;
  int   fails = 0;

  // Reference model: plain integers following the game rules.
  int m_state, m_score, m_lives, m_bricks, m_timer;
  bit m_award, m_serve, m_clr;

  function automatic void m_reset();
    m_state = S_IDLE; m_score = 0; m_lives = 0; m_bricks = N_BRICKS;
    m_timer = 0; m_award = 0; m_serve = 0; m_clr = 0;
  endfunction

  function automatic void m_step(input bit fs, input bit bh, input bit bl, input bit sb);
    int nxt;
    bit start, gr, wall_done;
    nxt = m_state; start = 0; gr = 0;
    wall_done = bh && (m_bricks == 1);
    m_serve = 0; m_clr = 0;
    case (m_state)
      S_IDLE:  start = sb;
      S_SERVE: if (m_timer == F_SERVE) begin nxt = S_PLAY; m_serve = 1; end
      S_PLAY: begin
        if (bh) begin
`ifdef EXTRA_LIFE_EN
          if (m_score == 49) gr = 1;
          if (m_score >= 98 && !m_award) begin gr = 1; m_award = 1; end
`endif
          if (m_score < 99) m_score = m_score + 1;
          m_bricks = m_bricks - 1;
        end
        if (wall_done) begin
          nxt = S_CLEAR;
          if (gr && m_lives < 9) m_lives = m_lives + 1;
        end else if (bl) begin
          if (gr) nxt = S_LOST;
          else begin
            m_lives = m_lives - 1;
            nxt = (m_lives == 0) ? S_OVER : S_LOST;
          end
        end else if (gr && m_lives < 9) begin
          m_lives = m_lives + 1;
        end
      end
      S_LOST:  if (m_timer == F_LOST) nxt = S_SERVE;
      S_CLEAR: if (m_timer == F_CLEAR) begin nxt = S_SERVE; m_clr = 1; m_bricks = N_BRICKS; end
      S_OVER: begin
        if (sb && m_timer >= 30) start = 1;
        else if (m_timer == F_OVER) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (start) begin
      nxt = S_SERVE; m_score = 0; m_lives = N_LIVES; m_bricks = N_BRICKS;
      m_award = 0; m_clr = 1;
    end
    m_timer = (nxt != m_state) ? 0 : (m_timer + int'(fs)) % 256;
    m_state = nxt;
  endfunction

  function automatic obs_t m_obs();
    obs_t o;
    o.s0  = 4'(m_score % 10);
    o.s1  = 4'(m_score / 10);
    o.lv  = 4'(m_lives);
    o.st  = 3'(m_state);
    o.frz = (m_state != S_PLAY);
    o.srv = m_serve;
    o.clr = m_clr;
    o.ovr = (m_state == S_OVER);
    return o;
  endfunction

  // Drive one clock's inputs at the falling edge and queue the predicted response.
  task automatic cycle(input bit rst, input bit fs, input bit bh, input bit bl, input bit sb);
    @(negedge clk);
    reset = rst; frame_start = fs; brick_hit = bh; ball_lost = bl; start_btn = sb;
    if (rst) m_reset();
    else m_step(fs, bh, bl, sb);
    exp_q.push_back(m_obs());
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic frames(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      bit bh, bl, sb;
      int gap;
      bh = noise && ($urandom_range(3) == 0);
      bl = noise && ($urandom_range(3) == 0);
      sb = noise && ($urandom_range(7) == 0);
      cycle(0, 1, bh, bl, sb);
      gap = (i == n - 1) ? 1 : 1 + int'($urandom_range(1));
      quiet(gap);
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, ($urandom_range(3) == 0), 1, 0, 0);
      if ($urandom_range(1) == 1) quiet(1);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every settled cycle with a prediction pending is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_got.s0 = score0; mon_got.s1 = score1; mon_got.lv = lives; mon_got.st = state;
        mon_got.frz = ball_freeze; mon_got.srv = ball_serve;
        mon_got.clr = clear_bricks; mon_got.ovr = game_over;
        tests++;
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL outputs @%0t: got score=%0d%0d lives=%0d state=%0d frz=%b srv=%b clr=%b ovr=%b, expected score=%0d%0d lives=%0d state=%0d frz=%b srv=%b clr=%b ovr=%b",
                   $time, mon_got.s1, mon_got.s0, mon_got.lv, mon_got.st, mon_got.frz,
                   mon_got.srv, mon_got.clr, mon_got.ovr, mon_exp.s1, mon_exp.s0,
                   mon_exp.lv, mon_exp.st, mon_exp.frz, mon_exp.srv, mon_exp.clr, mon_exp.ovr);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_state", state, S_IDLE);
    chk("reset_freeze", ball_freeze, 1);
    chk("reset_lives", lives, 0);
    chk("reset_score", {score1, score0}, 0);
    chk("reset_pulses", {ball_serve, clear_bricks, game_over}, 0);

    // Game 1: serve, scoring, saturation, losses, game over.
    cycle(0, 0, 0, 0, 1);
    quiet(1);
    chk("start_state", state, S_SERVE);
    chk("start_lives", lives, 3);
    chk("start_clear_pulse", clear_bricks, 1);
    quiet(1);
    chk("start_clear_done", clear_bricks, 0);
    frames(F_SERVE, 1);
    quiet(1);
    chk("serve_pulse", ball_serve, 1);
    chk("serve_to_play", state, S_PLAY);
    hits(15);
    quiet(1);
    chk("score15_tens", score1, 1);
    chk("score15_ones", score0, 5);
    hits(100);
    quiet(1);
    chk("score_sat", {score1, score0}, 8'h99);
    cycle(0, 0, 0, 0, 1);
    quiet(1);
    chk("start_in_play", state, S_PLAY);
    cycle(0, 0, 0, 1, 0);
    quiet(1);
    chk("lost_lives", lives, 2);
    chk("lost_state", state, S_LOST);
    frames(F_LOST, 1);
    quiet(1);
    chk("lost_to_serve", state, S_SERVE);
    chk("noise_ignored", {score1, score0}, 8'h99);
    frames(F_SERVE, 1);
    cycle(0, 0, 0, 1, 0);
    frames(F_LOST, 1);
    frames(F_SERVE, 1);
    quiet(1);
    chk("lives_before_over", lives, 1);
    cycle(0, 0, 0, 1, 0);
    quiet(1);
    chk("over_state", state, S_OVER);
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    frames(5, 0);
    cycle(0, 0, 0, 0, 1);
    quiet(1);
    chk("over_debounce", state, S_OVER);
    frames(F_OVER - 5, 0);
    quiet(1);
    chk("over_to_idle", state, S_IDLE);

    // Game 2: extra-life boundary, simultaneous hit and loss, wall reload.
    cycle(0, 0, 0, 0, 1);
    frames(F_SERVE, 1);
    cycle(0, 0, 0, 1, 0);
    frames(F_LOST, 1);
    frames(F_SERVE, 1);
    quiet(1);
    hits(49);
    quiet(1);
    chk("score49", {score1, score0}, 8'h49);
    chk("lives_at49", lives, 2);
    hits(1);
    quiet(1);
    chk("score50", {score1, score0}, 8'h50);
`ifdef EXTRA_LIFE_EN
    chk("lives_at50", lives, 3);
`else
    chk("lives_at50", lives, 2);
`endif
    hits(77);
    quiet(1);
    chk("one_brick_left", state, S_PLAY);
    cycle(0, 0, 1, 1, 0);
    quiet(1);
    chk("hit_lost_clear", state, S_CLEAR);
`ifdef EXTRA_LIFE_EN
    chk("hit_lost_lives", lives, 4);
`else
    chk("hit_lost_lives", lives, 2);
`endif
    frames(F_CLEAR, 1);
    quiet(1);
    chk("clear_to_serve", state, S_SERVE);
    chk("clear_reload_pulse", clear_bricks, 1);
    frames(F_SERVE, 1);
    hits(127);
    quiet(1);
    chk("reload_127", state, S_PLAY);
    hits(1);
    quiet(1);
    chk("reload_128", state, S_CLEAR);
    frames(F_CLEAR, 1);
    frames(F_SERVE, 1);
    quiet(2);
    chk("play_before_reset", state, S_PLAY);
    cycle(1, 0, 0, 0, 0);
    #1;
    chk("async_reset_state", state, S_IDLE);
    chk("async_reset_freeze", ball_freeze, 1);
    chk("async_reset_lives", lives, 0);
    chk("async_reset_score", {score1, score0}, 0);
    quiet(1);

    // Game 3: restart from OVER after the debounce window.
    cycle(0, 0, 0, 0, 1);
    frames(F_SERVE, 1);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 1, 0);
      frames(F_LOST, 1);
      frames(F_SERVE, 1);
    end
    quiet(1);
    cycle(0, 0, 0, 1, 0);
    quiet(1);
    chk("g3_over", state, S_OVER);
    frames(35, 0);
    cycle(0, 0, 0, 0, 1);
    quiet(1);
    chk("over_restart_state", state, S_SERVE);
    chk("over_restart_lives", lives, 3);
    chk("over_restart_clear", clear_bricks, 1);
    quiet(3);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
